// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conv_pkg
//  Purpose  : Shared types, width helper and LeNet layer defaults for the
//             convolution layer controller.
//  Revision : 1.0  initial release
// ============================================================================
package conv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD_BIAS = 3'd1,
      ST_MAC       = 3'd2,
      ST_DRAIN     = 3'd3,
      ST_STORE     = 3'd4,
      ST_NEXT      = 3'd5,
      ST_DONE      = 3'd6
   } conv_state_e;

   // Bits needed to hold the values 0..n-1 (never less than one bit).
   function automatic int width_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // LeNet C1
   localparam int c_c1_ksize    = 5;
   localparam int c_c1_in_ch    = 1;
   localparam int c_c1_out_ch   = 6;
   localparam int c_c1_out_rows = 28;
   localparam int c_c1_in_rows  = 32;

   // LeNet C3
   localparam int c_c3_ksize    = 5;
   localparam int c_c3_in_ch    = 6;
   localparam int c_c3_out_ch   = 16;
   localparam int c_c3_out_rows = 10;
   localparam int c_c3_in_rows  = 14;

endpackage
`default_nettype wire

// File: rtl/conv_tap_counter.sv
`default_nettype none
// ============================================================================
//  Module   : conv_tap_counter
//  Purpose  : Nested kx/ky/ic kernel-tap counters with flat tap index and
//             last-tap flag.
//  Revision : 1.0  initial release
// ============================================================================
module conv_tap_counter
   import conv_pkg::*;
#(
   parameter int KSIZE = 5,
   parameter int IN_CH = 1
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   clr,
   input  logic                                   adv,
   output logic [width_of(KSIZE)-1:0]             kx,
   output logic [width_of(KSIZE)-1:0]             ky,
   output logic [width_of(IN_CH)-1:0]             ic,
   output logic [width_of(KSIZE*KSIZE*IN_CH)-1:0] tap,
   output logic                                   last
);

   localparam int c_taps = KSIZE * KSIZE * IN_CH;
   localparam int c_kw   = width_of(KSIZE);
   localparam int c_tw   = width_of(c_taps);

   logic [c_kw-1:0]            r_kx;
   logic [c_kw-1:0]            r_ky;
   logic [width_of(IN_CH)-1:0] r_ic;
   logic [c_tw-1:0]            r_tap;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_kx  <= '0;
         r_ky  <= '0;
         r_ic  <= '0;
         r_tap <= '0;
      end else if (adv) begin
         if (last) begin
            r_kx  <= '0;
            r_ky  <= '0;
            r_ic  <= '0;
            r_tap <= '0;
         end else begin
            r_tap <= r_tap + 1'b1;
            if (r_kx == c_kw'(KSIZE - 1)) begin
               r_kx <= '0;
               if (r_ky == c_kw'(KSIZE - 1)) begin
                  r_ky <= '0;
                  r_ic <= r_ic + 1'b1;
               end else begin
                  r_ky <= r_ky + 1'b1;
               end
            end else begin
               r_kx <= r_kx + 1'b1;
            end
         end
      end
   end

   assign kx   = r_kx;
   assign ky   = r_ky;
   assign ic   = r_ic;
   assign tap  = r_tap;
   assign last = (r_tap == c_tw'(c_taps - 1));

endmodule
`default_nettype wire

// File: rtl/conv_layer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : conv_layer_ctrl
//  Purpose  : Sequencer for one convolution layer: bias/weight/fm reads, MAC
//             strobes and output row writes. Define CONV_LAYER_CTRL_RELU_EN
//             to zero negative output lanes.
//  Revision : 1.0  initial release
// ============================================================================
module conv_layer_ctrl
   import conv_pkg::*;
#(
   parameter int KSIZE         = c_c1_ksize,
   parameter int IN_CH         = c_c1_in_ch,
   parameter int OUT_CH        = c_c1_out_ch,
   parameter int OUT_ROWS      = c_c1_out_rows,
   parameter int IN_ROWS       = c_c1_in_rows,
   parameter int ROWS_PER_PASS = 4,
   parameter int LANES         = 28,
   parameter int DW            = 16,
   parameter int MAC_LAT       = 5,
   parameter int W_AW          = 12,
   parameter int FM_AW         = 7,
   parameter int B_AW          = 7,
   parameter int OUT_AW        = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   output logic                                busy,
   output logic                                done,
   output logic                                w_en,
   output logic [W_AW-1:0]                     w_addr,
   output logic                                fm_en,
   output logic [FM_AW-1:0]                    fm_addr,
   output logic                                bias_en,
   output logic [B_AW-1:0]                     bias_addr,
   output logic                                mac_en,
   output logic                                acc_clr,
   input  logic [ROWS_PER_PASS*LANES*DW-1:0]   mac_data,
   output logic                                out_we,
   output logic [OUT_AW-1:0]                   out_addr,
   output logic [LANES*DW-1:0]                 out_din
);

   localparam int c_taps  = KSIZE * KSIZE * IN_CH;
   localparam int c_row_w = LANES * DW;
   localparam int c_ocw   = width_of(OUT_CH);
   localparam int c_rbw   = width_of(OUT_ROWS + 1);
   localparam int c_cnw   = width_of((MAC_LAT > ROWS_PER_PASS) ? MAC_LAT : ROWS_PER_PASS);
   localparam longint c_fm_max = longint'((IN_CH - 1) * IN_ROWS + OUT_ROWS - ROWS_PER_PASS + KSIZE - 1);

   if (OUT_ROWS % ROWS_PER_PASS != 0) begin : g_chk_rows
      $error("OUT_ROWS must be a multiple of ROWS_PER_PASS");
   end
   if (MAC_LAT < 1) begin : g_chk_lat
      $error("MAC_LAT must be at least 1");
   end
   if (longint'(OUT_CH * c_taps) > (longint'(1) << W_AW)) begin : g_chk_w_aw
      $error("W_AW too narrow for the weight address range");
   end
   if (c_fm_max >= (longint'(1) << FM_AW)) begin : g_chk_fm_aw
      $error("FM_AW too narrow for the feature-map address range");
   end
   if (longint'(OUT_CH) > (longint'(1) << B_AW)) begin : g_chk_b_aw
      $error("B_AW too narrow for the bias address range");
   end
   if (longint'(OUT_CH * OUT_ROWS) > (longint'(1) << OUT_AW)) begin : g_chk_out_aw
      $error("OUT_AW too narrow for the output address range");
   end

   conv_state_e r_state;
   conv_state_e w_state_nxt;

   logic [c_ocw-1:0]                     r_oc;
   logic [c_rbw-1:0]                     r_row_base;
   logic [c_cnw-1:0]                     r_cnt;
   logic [c_rbw-1:0]                     w_rb_step;
   logic                                 w_group_end;
   logic                                 w_layer_end;

   logic [width_of(KSIZE)-1:0]           w_kx;
   logic [width_of(KSIZE)-1:0]           w_ky;
   logic [width_of(IN_CH)-1:0]           w_ic;
   logic [width_of(c_taps)-1:0]          w_tap;
   logic                                 w_last;

   logic [c_row_w-1:0]                   w_row;
   logic [c_row_w-1:0]                   w_row_din;

   logic                                 r_mac_en;
   logic                                 r_acc_clr;
   logic                                 r_out_we;
   logic [OUT_AW-1:0]                    r_out_addr;
   logic [c_row_w-1:0]                   r_out_din;

   conv_tap_counter #(
      .KSIZE (KSIZE),
      .IN_CH (IN_CH)
   ) u_taps (
      .clk  (clk),
      .rst  (rst),
      .clr  (r_state == ST_LOAD_BIAS),
      .adv  (r_state == ST_MAC),
      .kx   (w_kx),
      .ky   (w_ky),
      .ic   (w_ic),
      .tap  (w_tap),
      .last (w_last)
   );

   assign w_rb_step   = r_row_base + c_rbw'(ROWS_PER_PASS);
   assign w_group_end = (w_rb_step == c_rbw'(OUT_ROWS));
   assign w_layer_end = w_group_end && (r_oc == c_ocw'(OUT_CH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:      if (start) w_state_nxt = ST_LOAD_BIAS;
         ST_LOAD_BIAS: w_state_nxt = ST_MAC;
         ST_MAC:       if (w_last) w_state_nxt = ST_DRAIN;
         ST_DRAIN:     if (r_cnt == c_cnw'(MAC_LAT - 1)) w_state_nxt = ST_STORE;
         ST_STORE:     if (r_cnt == c_cnw'(ROWS_PER_PASS - 1)) w_state_nxt = ST_NEXT;
         ST_NEXT:      w_state_nxt = w_layer_end ? ST_DONE : ST_LOAD_BIAS;
         ST_DONE:      w_state_nxt = ST_IDLE;
         default:      w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = (r_state != ST_IDLE);
      done      = (r_state == ST_DONE);
      bias_en   = 1'b0;
      bias_addr = '0;
      w_en      = 1'b0;
      w_addr    = '0;
      fm_en     = 1'b0;
      fm_addr   = '0;
      case (r_state)
         ST_LOAD_BIAS: begin
            bias_en   = 1'b1;
            bias_addr = B_AW'(r_oc);
         end
         ST_MAC: begin
            w_en   = 1'b1;
            w_addr = W_AW'(32'(r_oc) * 32'(c_taps) + 32'(w_tap));
            // One fm row read per kernel row; the MAC array walks kx itself.
            if (w_kx == '0) begin
               fm_en   = 1'b1;
               fm_addr = FM_AW'(32'(w_ic) * 32'(IN_ROWS) + 32'(r_row_base) + 32'(w_ky));
            end
         end
         default: ;
      endcase
   end

   // r_cnt doubles as the drain timer and the store row index.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= '0;
         r_oc       <= '0;
         r_row_base <= '0;
      end else begin
         if (w_state_nxt != r_state) begin
            r_cnt <= '0;
         end else if ((r_state == ST_DRAIN) || (r_state == ST_STORE)) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (r_state == ST_NEXT) begin
            if (w_group_end) begin
               r_row_base <= '0;
               r_oc       <= w_layer_end ? '0 : r_oc + 1'b1;
            end else begin
               r_row_base <= w_rb_step;
            end
         end
      end
   end

   assign w_row = mac_data[32'(r_cnt) * c_row_w +: c_row_w];

   for (genvar l = 0; l < LANES; l++) begin : g_lane
`ifdef CONV_LAYER_CTRL_RELU_EN
      assign w_row_din[l*DW +: DW] = w_row[l*DW + DW - 1] ? '0 : w_row[l*DW +: DW];
`else
      assign w_row_din[l*DW +: DW] = w_row[l*DW +: DW];
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mac_en   <= 1'b0;
         r_acc_clr  <= 1'b0;
         r_out_we   <= 1'b0;
         r_out_addr <= '0;
         r_out_din  <= '0;
      end else begin
         r_mac_en  <= w_en;
         r_acc_clr <= w_en && (w_tap == '0);
         r_out_we  <= (r_state == ST_STORE);
         if (r_state == ST_STORE) begin
            r_out_addr <= OUT_AW'(32'(r_oc) * 32'(OUT_ROWS) + 32'(r_row_base) + 32'(r_cnt));
            r_out_din  <= w_row_din;
         end else begin
            r_out_addr <= '0;
            r_out_din  <= '0;
         end
      end
   end

   assign mac_en   = r_mac_en;
   assign acc_clr  = r_acc_clr;
   assign out_we   = r_out_we;
   assign out_addr = r_out_addr;
   assign out_din  = r_out_din;

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_layer_ctrl
//  Purpose  : Cycle-accurate check of two controller builds (5x5x1, 3x3x2)
//             against a pass/phase timeline model of the layer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv_layer_ctrl;

   localparam int OUT_CH   = 6;
   localparam int OUT_ROWS = 28;
   localparam int IN_ROWS  = 32;
   localparam int RPP      = 4;
   localparam int LANES    = 28;
   localparam int DW       = 16;
   localparam int MAC_LAT  = 5;
   localparam int W_AW     = 12;
   localparam int FM_AW    = 7;
   localparam int B_AW     = 7;
   localparam int OUT_AW   = 8;
   localparam int ROW_W    = LANES * DW;
   localparam int MAC_W    = RPP * ROW_W;
   localparam int PASSES   = OUT_CH * (OUT_ROWS / RPP);
   localparam int N_RUN    = 1513 + 8;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic [MAC_W-1:0] mac_data;

   logic a_busy, a_done, a_w_en, a_fm_en, a_bias_en, a_mac_en, a_acc_clr, a_out_we;
   logic [W_AW-1:0] a_w_addr;
   logic [FM_AW-1:0] a_fm_addr;
   logic [B_AW-1:0] a_bias_addr;
   logic [OUT_AW-1:0] a_out_addr;
   logic [ROW_W-1:0] a_out_din;

   logic b_busy, b_done, b_w_en, b_fm_en, b_bias_en, b_mac_en, b_acc_clr, b_out_we;
   logic [W_AW-1:0] b_w_addr;
   logic [FM_AW-1:0] b_fm_addr;
   logic [B_AW-1:0] b_bias_addr;
   logic [OUT_AW-1:0] b_out_addr;
   logic [ROW_W-1:0] b_out_din;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   conv_layer_ctrl u_dut_a (
      .clk(clk), .rst(rst), .start(start), .busy(a_busy), .done(a_done),
      .w_en(a_w_en), .w_addr(a_w_addr), .fm_en(a_fm_en), .fm_addr(a_fm_addr),
      .bias_en(a_bias_en), .bias_addr(a_bias_addr), .mac_en(a_mac_en),
      .acc_clr(a_acc_clr), .mac_data(mac_data), .out_we(a_out_we),
      .out_addr(a_out_addr), .out_din(a_out_din)
   );

   conv_layer_ctrl #(.KSIZE(3), .IN_CH(2)) u_dut_b (
      .clk(clk), .rst(rst), .start(start), .busy(b_busy), .done(b_done),
      .w_en(b_w_en), .w_addr(b_w_addr), .fm_en(b_fm_en), .fm_addr(b_fm_addr),
      .bias_en(b_bias_en), .bias_addr(b_bias_addr), .mac_en(b_mac_en),
      .acc_clr(b_acc_clr), .mac_data(mac_data), .out_we(b_out_we),
      .out_addr(b_out_addr), .out_din(b_out_din)
   );

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] pk(
      input logic b, input logic d, input logic be, input logic [B_AW-1:0] ba,
      input logic we, input logic [W_AW-1:0] wa, input logic fe,
      input logic [FM_AW-1:0] fa, input logic me, input logic ac,
      input logic oe, input logic [OUT_AW-1:0] oa);
      return {22'd0, b, d, be, ba, we, wa, fe, fa, me, ac, oe, oa};
   endfunction

   function automatic int pass_len(input int k, input int c);
      return 2 + k * k * c + MAC_LAT + RPP;
   endfunction

   function automatic bool_active(input int n, input int k, input int c, input int rst_at);
      return (n >= 1) && (n <= PASSES * pass_len(k, c)) && !(rst_at > 0 && n > rst_at);
   endfunction

   // Output row index written at cycle n, or -1 when no write is due.
   function automatic int store_slot(input int n, input int k, input int c, input int rst_at);
      int s;
      if (!bool_active(n, k, c, rst_at)) return -1;
      s = (n - 1) % pass_len(k, c) - (2 + k * k * c + MAC_LAT);
      return (s >= 0 && s < RPP) ? s : -1;
   endfunction

   function automatic logic [63:0] exp_ctl(input int n, input int k, input int c, input int rst_at);
      int taps, ph, p, oc, rb, t, s;
      logic be, we, fe, me, ac, oe;
      int ba, wa, fa, oa;
      taps = k * k * c;
      be = 0; we = 0; fe = 0; me = 0; ac = 0; oe = 0;
      ba = 0; wa = 0; fa = 0; oa = 0;
      if (n == PASSES * pass_len(k, c) + 1 && !(rst_at > 0 && n > rst_at))
         return pk(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
      if (!bool_active(n, k, c, rst_at))
         return 64'd0;
      ph = (n - 1) % pass_len(k, c);
      p  = (n - 1) / pass_len(k, c);
      oc = p / (OUT_ROWS / RPP);
      rb = (p % (OUT_ROWS / RPP)) * RPP;
      if (ph == 0) begin
         be = 1;
         ba = oc;
      end
      if (ph >= 1 && ph <= taps) begin
         t  = ph - 1;
         we = 1;
         wa = oc * taps + t;
         if (t % k == 0) begin
            fe = 1;
            fa = (t / (k * k)) * IN_ROWS + rb + (t / k) % k;
         end
      end
      if (ph >= 2 && ph <= taps + 1) begin
         me = 1;
         ac = (ph == 2);
      end
      s = store_slot(n, k, c, rst_at);
      if (s >= 0) begin
         oe = 1;
         oa = oc * OUT_ROWS + rb + s;
      end
      return pk(1'b1, 1'b0, be, B_AW'(ba), we, W_AW'(wa), fe, FM_AW'(fa), me, ac, oe, OUT_AW'(oa));
   endfunction

   function automatic logic [ROW_W-1:0] relu_row(input logic [ROW_W-1:0] x);
      logic [ROW_W-1:0] y;
      y = x;
`ifdef CONV_LAYER_CTRL_RELU_EN
      for (int l = 0; l < LANES; l++)
         if (x[l*DW + DW - 1]) y[l*DW +: DW] = '0;
`endif
      return y;
   endfunction

   task automatic drive_mac();
      for (int l = 0; l < RPP * LANES; l++) begin
         case ($urandom_range(0, 3))
            0:       mac_data[l*DW +: DW] = 16'h8001;
            1:       mac_data[l*DW +: DW] = 16'h7FFF;
            default: mac_data[l*DW +: DW] = DW'($urandom);
         endcase
      end
   endtask

   task automatic run_layer(input int rst_at);
      int done_a = 0, done_b = 0, ndone = 0, we_cnt = 0, covered = 0, sa, sb;
      int hits[OUT_CH*OUT_ROWS];
      int lim;
      foreach (hits[i]) hits[i] = 0;
      lim = (rst_at > 0) ? rst_at : 1200;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 1; n <= N_RUN; n++) begin
         check("a_ctl", 512'(pk(a_busy, a_done, a_bias_en, a_bias_addr, a_w_en, a_w_addr,
               a_fm_en, a_fm_addr, a_mac_en, a_acc_clr, a_out_we, a_out_addr)),
               512'(exp_ctl(n, 5, 1, rst_at)));
         check("b_ctl", 512'(pk(b_busy, b_done, b_bias_en, b_bias_addr, b_w_en, b_w_addr,
               b_fm_en, b_fm_addr, b_mac_en, b_acc_clr, b_out_we, b_out_addr)),
               512'(exp_ctl(n, 3, 2, rst_at)));
         sa = store_slot(n, 5, 1, rst_at);
         sb = store_slot(n, 3, 2, rst_at);
         if (sa >= 0) check("a_din", 512'(a_out_din), 512'(relu_row(mac_data[sa*ROW_W +: ROW_W])));
         if (sb >= 0) check("b_din", 512'(b_out_din), 512'(relu_row(mac_data[sb*ROW_W +: ROW_W])));
         if (a_done === 1'b1 && done_a == 0) done_a = n;
         if (b_done === 1'b1 && done_b == 0) done_b = n;
         if (a_done === 1'b1 || b_done === 1'b1) ndone++;
         if (a_out_we === 1'b1) begin
            we_cnt++;
            if (int'(a_out_addr) < OUT_CH * OUT_ROWS) hits[a_out_addr]++;
         end
         rst   = (rst_at > 0 && n == rst_at);
         start = (n > 1 && n < lim && (n == 300 || $urandom_range(0, 99) < 2));
         drive_mac();
         @(posedge clk); #1;
      end
      rst   = 1'b0;
      start = 1'b0;
      if (rst_at == 0) begin
         foreach (hits[i]) if (hits[i] == 1) covered++;
         check("a_done_at", 512'(done_a), 512'(1513));
         check("b_done_at", 512'(done_b), 512'(PASSES * (2 + 18 + MAC_LAT + RPP) + 1));
         check("a_we_count", 512'(we_cnt), 512'(OUT_CH * OUT_ROWS));
         check("a_addr_once", 512'(covered), 512'(OUT_CH * OUT_ROWS));
      end else begin
         check("abort_no_done", 512'(ndone), 512'(0));
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      drive_mac();
      repeat (3) @(posedge clk);
      #1;
      check("reset_a", 512'(pk(a_busy, a_done, a_bias_en, a_bias_addr, a_w_en, a_w_addr,
            a_fm_en, a_fm_addr, a_mac_en, a_acc_clr, a_out_we, a_out_addr)), 512'(0));
      check("reset_b", 512'(pk(b_busy, b_done, b_bias_en, b_bias_addr, b_w_en, b_w_addr,
            b_fm_en, b_fm_addr, b_mac_en, b_acc_clr, b_out_we, b_out_addr)), 512'(0));
      check("reset_din", 512'({a_out_din, b_out_din} != '0), 512'(0));
      rst = 1'b0;
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      check("idle_a", 512'({a_busy, a_done, a_out_we}), 512'(0));
      run_layer(0);
      repeat (3) @(posedge clk);
      #1;
      run_layer(500);
      repeat (2) @(posedge clk);
      #1;
      run_layer(0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/conv_layer_ctrl.md
Name: conv_layer_ctrl

Overview:
Parametrised sequencer for one convolution layer of the LeNet accelerator. It is the generalised successor of the fixed 5x5, 6-channel first-layer controller.
- Drives weight, feature-map and bias BRAM reads, and MAC enable/clear.
- Writes ROWS_PER_PASS output rows per pass into the output feature-map BRAM.
- Iterates over all output channels and row groups.
- Sits between the top-level layer scheduler (start/done) and the shared MAC array.

Parameters:
KSIZE, 5, kernel width/height
IN_CH, 1, input channels
OUT_CH, 6, output channels
OUT_ROWS, 28, output rows per channel; must be a multiple of ROWS_PER_PASS (elaboration error otherwise)
IN_ROWS, 32, input rows per input channel in fm BRAM
ROWS_PER_PASS, 4, output rows computed per MAC pass
LANES, 28, output pixels per row
DW, 16, data word width
MAC_LAT, 5, MAC pipeline latency after the last tap
W_AW, 12, weight address width
FM_AW, 7, input fm address width
B_AW, 7, bias address width
OUT_AW, 8, output fm address width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins the layer
busy  out  1  high from LOAD_BIAS until DONE inclusive
done  out  1  one-cycle pulse at layer end
w_en  out  1  weight BRAM read enable
w_addr  out  W_AW  weight address
fm_en  out  1  input fm BRAM read enable
fm_addr  out  FM_AW  input fm row address
bias_en  out  1  bias BRAM read enable
bias_addr  out  B_AW  bias address (= output channel)
mac_en  out  1  MAC accumulate strobe, aligned to BRAM read data
acc_clr  out  1  clear accumulators, aligned with the first mac_en of a pass
mac_data  in  ROWS_PER_PASS*LANES*DW  MAC results; row r occupies slice [r*LANES*DW +: LANES*DW]
out_we  out  1  output fm write enable
out_addr  out  OUT_AW  output fm address
out_din  out  LANES*DW  output row data

Behaviour:
- Reset: FSM to IDLE. All outputs and counters are 0.
- Reset mid-layer: abort immediately. No further writes occur.
- FSM states: IDLE, LOAD_BIAS, MAC, DRAIN, STORE, NEXT, DONE.
- IDLE: start=1 moves to LOAD_BIAS next cycle. start while busy is ignored.
- LOAD_BIAS (1 cycle): bias_en=1, bias_addr=oc.
- MAC (KSIZE*KSIZE*IN_CH cycles): tap index t runs with kx fastest, then ky, then ic.
  - w_en=1; w_addr = oc*KSIZE*KSIZE*IN_CH + t.
  - fm_en=1 only when kx==0; fm_addr = ic*IN_ROWS + row_base + ky.
  - mac_en = w_en delayed 1 cycle. acc_clr = (t==0) delayed 1 cycle.
- DRAIN: MAC_LAT cycles with no strobes.
- STORE (ROWS_PER_PASS cycles, r = 0..RPP-1):
  - out_we=1; out_addr = oc*OUT_ROWS + row_base + r; out_din = row r slice of mac_data.
  - out_addr and out_din are registered together with out_we.
- NEXT (1 cycle): row_base += ROWS_PER_PASS.
  - If row_base hits OUT_ROWS: row_base=0 and oc++.
  - If oc was OUT_CH-1: go to DONE. Otherwise go to LOAD_BIAS.
- DONE (1 cycle): done=1, then IDLE.
- Cycles per pass P = 2 + KSIZE*KSIZE*IN_CH + MAC_LAT + ROWS_PER_PASS.
- done rises exactly OUT_CH*(OUT_ROWS/ROWS_PER_PASS)*P + 1 cycles after the cycle start is sampled. With defaults: 42*36+1 = 1513.
- Address arithmetic is unsigned and truncated to the port width. The widths must cover the maximum address; elaboration asserts this.

Optional Feature:
CONV_LAYER_CTRL_RELU_EN
- Defined: each DW-bit lane of out_din with its sign bit set is written as 0. Adds no latency.
- Undefined: out_din is passed through unchanged.

Decomposition:
- conv_pkg holds:
  - the FSM state enum
  - a clog2-based width helper function
  - the default-parameter constants (LeNet C1/C3 sets)
- One sub-module, conv_tap_counter: kx/ky/ic nested counters with clear, advance, tap-index output and last-tap flag. The FSM and address math stay in conv_layer_ctrl.

Test Plan:
- Defaults; pulse start -> busy next cycle; done exactly 1513 cycles after start; 168 out_we pulses total, one per address 0..167, each once.
- Pass oc=1, row_base=0 -> first w_addr=25, last w_addr=49. fm_en pulses at fm_addr 0,1,2,3,4. acc_clr coincides with the first mac_en.
- Pass oc=2, row_base=8, r=1 -> out_addr=65; out_din equals mac_data row-1 slice.
- IN_CH=2, IN_ROWS=32, KSIZE=3 -> MAC state lasts 18 cycles; fm_addr for ic=1, ky=0, row_base=4 is 36.
- start re-pulsed mid-layer -> ignored, total cycle count unchanged. rst at cycle 500 -> next cycle all outputs 0, FSM IDLE, no done pulse.
- RELU_EN defined, lane value 16'h8001 -> written as 0; 16'h7FFF -> written unchanged. Undefined -> 16'h8001 written.
